kmeans_k2n2_data_loader: RTL

KMEANS_K2N2_DATA_LOADER -- requirements
Module: kmeans_k2n2_data_loader

---
 rtl/kmeans_k2n2_data_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/kmeans_k2n2_data_loader.sv
// rtl/kmeans_k2n2_data_loader.sv - loads (d0,d1) points into the k-means point memories, then launches the core
// Optional running checksum of loaded coordinates: define KMEANS_LOADER_CHECKSUM_EN.
module kmeans_k2n2_data_loader #(
  parameter int data_width               = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_req,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [data_width-1:0]               in_d0,
  input  logic [data_width-1:0]               in_d1,
  output logic                                mem_wr_en,
  output logic [input_data_qty_bit_width-1:0] mem_wr_addr,
  output logic [data_width-1:0]               mem_wr_d0,
  output logic [data_width-1:0]               mem_wr_d1,
  output logic                                start,
  input  logic                                run_done,
  output logic                                busy
`ifdef KMEANS_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                         checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    START    = 2'd2,
    WAIT_RUN = 2'd3
  } state_t;

  // Terminal index is compared directly so a full 2^width load never wraps the counter.
  localparam logic [input_data_qty_bit_width-1:0] LAST_IDX =
    input_data_qty_bit_width'(input_data_qty - 1);

  state_t                              r_state;
  state_t                              w_state_next;
  logic [input_data_qty_bit_width-1:0] r_cnt;
  logic                                r_wr_en;
  logic [input_data_qty_bit_width-1:0] r_wr_addr;
  logic [data_width-1:0]               r_wr_d0;
  logic [data_width-1:0]               r_wr_d1;
  logic                                w_xfer;
  logic                                w_last;

  assign w_xfer = (r_state == LOAD) && in_valid;
  assign w_last = (r_cnt == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (load_req) w_state_next = LOAD;
      LOAD:     if (w_xfer && w_last) w_state_next = START;
      START:    w_state_next = WAIT_RUN;
      WAIT_RUN: if (run_done) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && load_req) begin
        r_cnt <= '0;
      end else if (w_xfer && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Write port is registered: the final write lands in the START cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_d0   <= '0;
      r_wr_d1   <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_addr <= r_cnt;
        r_wr_d0   <= in_d0;
        r_wr_d1   <= in_d1;
      end
    end
  end

`ifdef KMEANS_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if ((r_state == IDLE) && load_req) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + 16'(in_d0) + 16'(in_d1);
    end
  end

  assign checksum = r_checksum;
`endif

  assign in_ready    = (r_state == LOAD);
  assign busy        = (r_state != IDLE);
  assign start       = (r_state == START);
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_d0   = r_wr_d0;
  assign mem_wr_d1   = r_wr_d1;

endmodule
